// File: rtl/instr_enc_pkg.sv
// Shared constants for the RV32 instruction stream encoder: kind codes, opcode/funct fields,
// the NOP word and the loader FSM state encoding (ST_PAD exists only with INSTR_ENC_NOP_PAD_EN).
package instr_enc_pkg;

  localparam logic [2:0] KIND_AND  = 3'd0;
  localparam logic [2:0] KIND_XOR  = 3'd1;
  localparam logic [2:0] KIND_SLL  = 3'd2;
  localparam logic [2:0] KIND_ADD  = 3'd3;
  localparam logic [2:0] KIND_SUB  = 3'd4;
  localparam logic [2:0] KIND_MUL  = 3'd5;
  localparam logic [2:0] KIND_ADDI = 3'd6;
  localparam logic [2:0] KIND_SRAI = 3'd7;

  localparam logic [6:0] OPCODE_R = 7'b0110011;
  localparam logic [6:0] OPCODE_I = 7'b0010011;

  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SRAI = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;
  localparam logic [6:0] F7_SRA  = 7'b0100000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
`ifdef INSTR_ENC_NOP_PAD_EN
    ST_PAD  = 2'd2,
`endif
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPCODE_R};
  endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational descriptor-to-RV32 encoder for and/xor/sll/add/sub/mul/addi/srai.
module instr_field_encoder
  import instr_enc_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word
);

  // Field assembly per instruction kind; rs2 is unused by the I-type forms.
  always_comb begin
    word = NOP_WORD;
    case (kind)
      KIND_AND:  word = r_type(F7_BASE, rs2, rs1, F3_AND, rd);
      KIND_XOR:  word = r_type(F7_BASE, rs2, rs1, F3_XOR, rd);
      KIND_SLL:  word = r_type(F7_BASE, rs2, rs1, F3_SLL, rd);
      KIND_ADD:  word = r_type(F7_BASE, rs2, rs1, F3_ADD, rd);
      KIND_SUB:  word = r_type(F7_SUB,  rs2, rs1, F3_ADD, rd);
      KIND_MUL:  word = r_type(F7_MUL,  rs2, rs1, F3_ADD, rd);
      KIND_ADDI: word = {imm, rs1, F3_ADD, rd, OPCODE_I};
      KIND_SRAI: word = {F7_SRA, imm[4:0], rs1, F3_SRAI, rd, OPCODE_I};
      default:   word = NOP_WORD;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Streams encoded descriptors into instruction memory, then raises cpu_start_o.
// Optional NOP padding after the last descriptor is enabled by defining INSTR_ENC_NOP_PAD_EN.
module instr_stream_encoder
  import instr_enc_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 8,
  parameter int PAD_NOPS = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              last_i,
  input  logic [2:0]        kind_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [11:0]       imm_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              cpu_start_o
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ZERO_C  = (ADDR_W+1)'(0);

  if (ADDR_W != $clog2(DEPTH) || PAD_NOPS < 0) begin : g_bad_params
    $error("instr_stream_encoder: ADDR_W must equal clog2(DEPTH) and PAD_NOPS must be >= 0");
  end

  state_e            state_r, state_nxt;
  logic [ADDR_W:0]   addr_r, addr_nxt;
  logic [ADDR_W:0]   count_r, count_nxt;
  logic              full_r, full_nxt;
  logic              we_r, we_nxt;
  logic [ADDR_W-1:0] waddr_r, waddr_nxt;
  logic [31:0]       wdata_r, wdata_nxt;
  logic              ready_r, ready_nxt;
  logic              cpu_start_r, cpu_start_nxt;
  logic              xfer;
  logic [31:0]       enc_word;
  logic [ADDR_W:0]   count_inc;

`ifdef INSTR_ENC_NOP_PAD_EN
  localparam int PAD_W = (PAD_NOPS > 1) ? $clog2(PAD_NOPS) : 1;
  localparam logic [PAD_W-1:0] PAD_LAST_C = PAD_W'(PAD_NOPS - 1);
  logic [PAD_W-1:0] pad_r, pad_nxt;
`endif

  instr_field_encoder u_enc (
    .kind (kind_i),
    .rd   (rd_i),
    .rs1  (rs1_i),
    .rs2  (rs2_i),
    .imm  (imm_i),
    .word (enc_word)
  );

  assign xfer      = valid_i & ready_r;
  assign count_inc = (count_r < DEPTH_C) ? (count_r + ONE_C) : count_r;

  // Next-state, counter and write-register logic; outputs are registered from these values.
  always_comb begin
    state_nxt = state_r;
    addr_nxt  = addr_r;
    count_nxt = count_r;
    full_nxt  = full_r;
    we_nxt    = 1'b0;
    waddr_nxt = waddr_r;
    wdata_nxt = wdata_r;
`ifdef INSTR_ENC_NOP_PAD_EN
    pad_nxt   = pad_r;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_nxt = ST_LOAD;
          addr_nxt  = ZERO_C;
          count_nxt = ZERO_C;
          full_nxt  = 1'b0;
        end else begin
          state_nxt = state_r;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          we_nxt    = 1'b1;
          waddr_nxt = addr_r[ADDR_W-1:0];
          wdata_nxt = enc_word;
          addr_nxt  = addr_r + ONE_C;
          count_nxt = count_inc;
          if (last_i) begin
`ifdef INSTR_ENC_NOP_PAD_EN
            // No room left (or nothing to pad): skip PAD; full_o stays clear either way.
            if (addr_r == LAST_C || PAD_NOPS == 0) begin
              state_nxt = ST_DONE;
            end else begin
              state_nxt = ST_PAD;
              pad_nxt   = {PAD_W{1'b0}};
            end
`else
            state_nxt = ST_DONE;
`endif
          end else if (addr_r == LAST_C) begin
            full_nxt  = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_LOAD;
          end
        end else begin
          state_nxt = ST_LOAD;
        end
      end
`ifdef INSTR_ENC_NOP_PAD_EN
      ST_PAD: begin
        we_nxt    = 1'b1;
        waddr_nxt = addr_r[ADDR_W-1:0];
        wdata_nxt = NOP_WORD;
        addr_nxt  = addr_r + ONE_C;
        count_nxt = count_inc;
        pad_nxt   = pad_r + PAD_W'(1);
        if (pad_r == PAD_LAST_C || addr_r == LAST_C) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_PAD;
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    ready_nxt     = (state_nxt == ST_LOAD) && (addr_nxt < DEPTH_C);
    cpu_start_nxt = (state_nxt == ST_DONE);
  end

  // State, counters and the registered memory write port.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r     <= ST_IDLE;
      addr_r      <= ZERO_C;
      count_r     <= ZERO_C;
      full_r      <= 1'b0;
      we_r        <= 1'b0;
      waddr_r     <= {ADDR_W{1'b0}};
      wdata_r     <= 32'h0000_0000;
      ready_r     <= 1'b0;
      cpu_start_r <= 1'b0;
`ifdef INSTR_ENC_NOP_PAD_EN
      pad_r       <= {PAD_W{1'b0}};
`endif
    end else begin
      state_r     <= state_nxt;
      addr_r      <= addr_nxt;
      count_r     <= count_nxt;
      full_r      <= full_nxt;
      we_r        <= we_nxt;
      waddr_r     <= waddr_nxt;
      wdata_r     <= wdata_nxt;
      ready_r     <= ready_nxt;
      cpu_start_r <= cpu_start_nxt;
`ifdef INSTR_ENC_NOP_PAD_EN
      pad_r       <= pad_nxt;
`endif
    end
  end

  assign ready_o     = ready_r;
  assign mem_we_o    = we_r;
  assign mem_addr_o  = waddr_r;
  assign mem_data_o  = wdata_r;
  assign count_o     = count_r;
  assign full_o      = full_r;
  assign cpu_start_o = cpu_start_r;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed, table-driven bench for instr_stream_encoder (DEPTH=256 instance plus a DEPTH=4 instance).
module tb_instr_stream_encoder;

  logic        clk = 1'b0;
  logic        rst, start, valid, last;
  logic [2:0]  kind;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm;

  logic        ready_a, we_a, full_a, cpu_a;
  logic [7:0]  addr_a;
  logic [31:0] data_a;
  logic [8:0]  count_a;

  logic        ready_b, we_b, full_b, cpu_b;
  logic [1:0]  addr_b;
  logic [31:0] data_b;
  logic [2:0]  count_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_stream_encoder #(.DEPTH(256), .ADDR_W(8), .PAD_NOPS(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid), .ready_o(ready_a),
    .last_i(last), .kind_i(kind), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .mem_we_o(we_a), .mem_addr_o(addr_a), .mem_data_o(data_a), .count_o(count_a),
    .full_o(full_a), .cpu_start_o(cpu_a)
  );

  instr_stream_encoder #(.DEPTH(4), .ADDR_W(2), .PAD_NOPS(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid), .ready_o(ready_b),
    .last_i(last), .kind_i(kind), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_data_o(data_b), .count_o(count_b),
    .full_o(full_b), .cpu_start_o(cpu_b)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] k, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [11:0] im, input logic v, input logic l);
    kind  = k;
    rd    = d;
    rs1   = s1;
    rs2   = s2;
    imm   = im;
    valid = v;
    last  = l;
  endtask

  initial begin
    logic [9:0] vp;
    logic [9:0] sp;
    int exp_addr;

    vecs[0] = '{3'd3, 5'd3,  5'd1,  5'd2,  12'h000, 32'h0020_81B3}; // ADD
    vecs[1] = '{3'd4, 5'd5,  5'd6,  5'd7,  12'h000, 32'h4073_02B3}; // SUB
    vecs[2] = '{3'd5, 5'd4,  5'd1,  5'd2,  12'h000, 32'h0220_8233}; // MUL
    vecs[3] = '{3'd6, 5'd1,  5'd0,  5'd31, 12'hFFF, 32'hFFF0_0093}; // ADDI, rs2 ignored
    vecs[4] = '{3'd7, 5'd2,  5'd1,  5'd31, 12'hFE3, 32'h4030_D113}; // SRAI, imm[11:5] ignored
    vecs[5] = '{3'd0, 5'd1,  5'd2,  5'd3,  12'h000, 32'h0031_70B3}; // AND
    vecs[6] = '{3'd1, 5'd10, 5'd11, 5'd12, 12'h000, 32'h00C5_C533}; // XOR
    vecs[7] = '{3'd2, 5'd31, 5'd31, 5'd31, 12'h000, 32'h01FF_9FB3}; // SLL
    vecs[8] = '{3'd6, 5'd7,  5'd9,  5'd0,  12'h123, 32'h1234_8393}; // ADDI

    rst = 1'b0;
    start = 1'b0;
    drive(3'd0, 5'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1'b0);
    step();
    step();
    chk("rst_we",    32'(we_a),    32'd0);
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_cpu",   32'(cpu_a),   32'd0);
    chk("rst_full",  32'(full_a),  32'd0);
    chk("rst_addr",  32'(addr_a),  32'd0);
    chk("rst_data",  data_a,       32'd0);

    // Single ADD with last
    rst = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ready", 32'(ready_a), 32'd1);
    chk("start_cpu",   32'(cpu_a),   32'd0);
    drive(3'd3, 5'd3, 5'd1, 5'd2, 12'h000, 1'b1, 1'b1);
    step();
    drive(3'd0, 5'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1'b0);
    chk("one_we",    32'(we_a),    32'd1);
    chk("one_addr",  32'(addr_a),  32'd0);
    chk("one_data",  data_a,       32'h0020_81B3);
    chk("one_count", 32'(count_a), 32'd1);
    chk("one_ready", 32'(ready_a), 32'd0);
`ifdef INSTR_ENC_NOP_PAD_EN
    chk("one_cpu_early", 32'(cpu_a), 32'd0);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("pad_we",   32'(we_a),   32'd1);
      chk("pad_addr", 32'(addr_a), 32'(j));
      chk("pad_data", data_a,      32'h0000_0013);
    end
    step();
    chk("pad_we_end", 32'(we_a),    32'd0);
    chk("pad_count",  32'(count_a), 32'd5);
    chk("pad_cpu",    32'(cpu_a),   32'd1);
`else
    chk("one_cpu", 32'(cpu_a), 32'd1);
    step();
    chk("one_we_end",  32'(we_a),  32'd0);
    chk("one_hold",    data_a,     32'h0020_81B3);
    chk("one_cpu_hld", 32'(cpu_a), 32'd1);
`endif

    // Back-to-back table, restart from DONE
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_count0", 32'(count_a), 32'd0);
    chk("b2b_cpu0",   32'(cpu_a),   32'd0);
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].kind, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b1, (i == 8));
      step();
      chk("b2b_we",    32'(we_a),    32'd1);
      chk("b2b_addr",  32'(addr_a),  32'(i));
      chk("b2b_data",  data_a,       vecs[i].exp);
      chk("b2b_count", 32'(count_a), 32'(i + 1));
    end
    drive(3'd0, 5'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1'b0);
`ifndef INSTR_ENC_NOP_PAD_EN
    step();
    chk("b2b_we_end", 32'(we_a),  32'd0);
    chk("b2b_cpu",    32'(cpu_a), 32'd1);
`endif
    repeat (6) step();

    // Gaps in valid, start pulses mid-LOAD
    start = 1'b1;
    step();
    start = 1'b0;
    vp = 10'b11_0100_1011;
    sp = 10'b00_0010_0100;
    exp_addr = 0;
    for (int k = 0; k < 10; k++) begin
      drive(3'd3, 5'(k), 5'd0, 5'd0, 12'h000, vp[k], 1'b0);
      start = sp[k];
      step();
      chk("gap_we", 32'(we_a), 32'(vp[k]));
      if (vp[k]) begin
        chk("gap_addr", 32'(addr_a), 32'(exp_addr));
        chk("gap_data", data_a, 32'h33 | (32'(k) << 7));
        exp_addr++;
      end
    end
    start = 1'b0;
    drive(3'd0, 5'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1'b0);
    step();
    chk("gap_we_end", 32'(we_a),    32'd0);
    chk("gap_count",  32'(count_a), 32'(exp_addr));
    chk("gap_ready",  32'(ready_a), 32'd1);
    chk("gap_cpu",    32'(cpu_a),   32'd0);

    // Reset mid-LOAD with a pending descriptor
    drive(3'd3, 5'd8, 5'd0, 5'd0, 12'h000, 1'b1, 1'b0);
    rst = 1'b0;
    step();
    chk("mrst_we",    32'(we_a),    32'd0);
    chk("mrst_count", 32'(count_a), 32'd0);
    chk("mrst_ready", 32'(ready_a), 32'd0);
    rst = 1'b1;
    step();
    chk("idle_we",    32'(we_a),    32'd0);
    chk("idle_ready", 32'(ready_a), 32'd0);
    valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    drive(3'd3, 5'd9, 5'd0, 5'd0, 12'h000, 1'b1, 1'b1);
    step();
    drive(3'd0, 5'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1'b0);
    chk("rs_we",    32'(we_a),    32'd1);
    chk("rs_addr",  32'(addr_a),  32'd0);
    chk("rs_data",  data_a,       32'h0000_04B3);
    chk("rs_count", 32'(count_a), 32'd1);
    repeat (6) step();

    // DEPTH=4 fill without last
    rst = 1'b0;
    step();
    rst = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("fill_ready0", 32'(ready_b), 32'd1);
    for (int k = 0; k < 5; k++) begin
      drive(3'd3, 5'(k), 5'd0, 5'd0, 12'h000, 1'b1, 1'b0);
      step();
      if (k < 4) begin
        chk("fill_we",    32'(we_b),    32'd1);
        chk("fill_addr",  32'(addr_b),  32'(k));
        chk("fill_data",  data_b,       32'h33 | (32'(k) << 7));
        chk("fill_count", 32'(count_b), 32'(k + 1));
      end else begin
        chk("fill_we5",    32'(we_b),    32'd0);
        chk("fill_count5", 32'(count_b), 32'd4);
        chk("big_full",    32'(full_a),  32'd0);
      end
      if (k == 3) begin
        chk("fill_ready", 32'(ready_b), 32'd0);
        chk("fill_full",  32'(full_b),  32'd1);
        chk("fill_cpu",   32'(cpu_b),   32'd1);
      end
    end
    drive(3'd0, 5'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1'b0);
    step();
    chk("fill_full_hold", 32'(full_b), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
